// File: rtl/rv32i_inenc_if.sv
// Descriptor-in / word-out bus of the RV32I instruction encoder.
// The slave modport is the encoder's view; the master modport is the loader's view.
`timescale 1ns/1ps
interface rv32i_inenc_if #(
   parameter int unsigned ERR_W = 8
);
   logic             clr_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [3:0]       cls_i;
   logic [4:0]       rd_i;
   logic [4:0]       rs1_i;
   logic [4:0]       rs2_i;
   logic [2:0]       funct3_i;
   logic [6:0]       funct7_i;
   logic [31:0]      imm_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [31:0]      word_o;
   logic [31:0]      addr_o;
   logic             err_o;
   logic [ERR_W-1:0] err_cnt_o;

   modport slave (
      input  clr_i, in_valid_i, cls_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
             out_ready_i,
      output in_ready_o, out_valid_o, word_o, addr_o, err_o, err_cnt_o
   );

   modport master (
      output clr_i, in_valid_i, cls_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
             out_ready_i,
      input  in_ready_o, out_valid_o, word_o, addr_o, err_o, err_cnt_o
   );
endinterface

// File: rtl/rv32i_inenc.sv
// RV32I instruction encoder: packs a decoded descriptor into a 32-bit word with a sequential
// instruction-memory address; descriptors whose immediate does not fit are consumed and counted.
`timescale 1ns/1ps
module rv32i_inenc #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ERR_W     = 8
) (
   input logic          clk_i,
   input logic          rst_i,
   rv32i_inenc_if.slave bus
);

   localparam logic [0:0] StEmpty = 1'b0;
   localparam logic [0:0] StFull  = 1'b1;

   localparam logic [3:0] ClsArr   = 4'd0;
   localparam logic [3:0] ClsAri   = 4'd1;
   localparam logic [3:0] ClsLd    = 4'd2;
   localparam logic [3:0] ClsSt    = 4'd3;
   localparam logic [3:0] ClsBr    = 4'd4;
   localparam logic [3:0] ClsJal   = 4'd5;
   localparam logic [3:0] ClsJalr  = 4'd6;
   localparam logic [3:0] ClsLui   = 4'd7;
   localparam logic [3:0] ClsAuipc = 4'd8;
   localparam logic [3:0] ClsEbc   = 4'd9;

   localparam logic [6:0] OpArr   = 7'h33;
   localparam logic [6:0] OpAri   = 7'h13;
   localparam logic [6:0] OpLd    = 7'h03;
   localparam logic [6:0] OpSt    = 7'h23;
   localparam logic [6:0] OpBr    = 7'h63;
   localparam logic [6:0] OpJal   = 7'h6F;
   localparam logic [6:0] OpJalr  = 7'h67;
   localparam logic [6:0] OpLui   = 7'h37;
   localparam logic [6:0] OpAuipc = 7'h17;
   localparam logic [6:0] OpEbc   = 7'h73;

   logic [0:0]       state_q, state_d;
   logic [31:0]      word_q, word_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      next_addr_q, next_addr_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [31:0] imm;
   logic        fits12, fits13, fits21, is_shift;
   logic [31:0] enc_word;
   logic        enc_legal;
   logic        out_valid, in_ready, accept;

   assign imm      = bus.imm_i;
   // An immediate fits N bits signed when every bit above the sign bit copies it.
   assign fits12   = (imm[31:11] == '0) || (imm[31:11] == '1);
   assign fits13   = (imm[31:12] == '0) || (imm[31:12] == '1);
   assign fits21   = (imm[31:20] == '0) || (imm[31:20] == '1);
   assign is_shift = (bus.funct3_i == 3'd1) || (bus.funct3_i == 3'd5);

   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b0;
      case (bus.cls_i)
         ClsArr: begin
            enc_word  = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, OpArr};
            enc_legal = 1'b1;
         end
         ClsAri: begin
            if (is_shift) begin
               enc_word  = {bus.funct7_i, imm[4:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OpAri};
               enc_legal = (imm[31:5] == '0);
            end else begin
               enc_word  = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OpAri};
               enc_legal = fits12;
            end
         end
         ClsLd: begin
            enc_word  = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OpLd};
            enc_legal = fits12;
         end
         ClsJalr: begin
            enc_word  = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OpJalr};
            enc_legal = fits12;
         end
         ClsEbc: begin
            enc_word  = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OpEbc};
            enc_legal = fits12;
         end
         ClsSt: begin
            enc_word  = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], OpSt};
            enc_legal = fits12;
         end
         ClsBr: begin
            enc_word  = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:1],
                         imm[11], OpBr};
            enc_legal = fits13 && !imm[0];
         end
         ClsJal: begin
            enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, OpJal};
            enc_legal = fits21 && !imm[0];
         end
         ClsLui: begin
            enc_word  = {imm[31:12], bus.rd_i, OpLui};
            enc_legal = (imm[11:0] == '0);
         end
         ClsAuipc: begin
            enc_word  = {imm[31:12], bus.rd_i, OpAuipc};
            enc_legal = (imm[11:0] == '0);
         end
         default: begin
            enc_word  = '0;
            enc_legal = 1'b0;
         end
      endcase
   end

   assign out_valid = (state_q == StFull);
   assign in_ready  = !out_valid || bus.out_ready_i;
   assign accept    = bus.in_valid_i && in_ready;

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      addr_d      = addr_q;
      next_addr_d = next_addr_q;
      err_d       = 1'b0;
      err_cnt_d   = err_cnt_q;
      if (bus.clr_i) begin
         // Clear wins over a same-cycle accept; the descriptor vanishes without an error.
         state_d     = StEmpty;
         next_addr_d = BASE_ADDR;
      end else if (accept && enc_legal) begin
         state_d     = StFull;
         word_d      = enc_word;
         addr_d      = next_addr_q;
         next_addr_d = next_addr_q + 32'd4;
      end else begin
         if (accept) begin
            err_d = 1'b1;
            if (!(&err_cnt_q)) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
         end
         if (bus.out_ready_i) begin
            state_d = StEmpty;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StEmpty;
         word_q      <= '0;
         addr_q      <= BASE_ADDR;
         next_addr_q <= BASE_ADDR;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         next_addr_q <= next_addr_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.word_o      = word_q;
   assign bus.addr_o      = addr_q;
   assign bus.err_o       = err_q;
   assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_rv32i_inenc.sv
// Self-checking bench for rv32i_inenc: fixed vectors, hand-written corner sequences, and a
// randomized run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_rv32i_inenc;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int NV = 20;

   typedef struct {
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        legal;
      logic [31:0] word;
   } vec_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   rv32i_inenc_if #(.ERR_W(8)) bus ();

   rv32i_inenc #(.BASE_ADDR(BASE), .ERR_W(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.cls_i    = v.cls;
      bus.rd_i     = v.rd;
      bus.rs1_i    = v.rs1;
      bus.rs2_i    = v.rs2;
      bus.funct3_i = v.f3;
      bus.funct7_i = v.f7;
      bus.imm_i    = v.imm;
   endtask

   function automatic vec_t mk(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm);
      vec_t v;
      v.cls = c; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm;
      v.legal = 1'b0; v.word = '0;
      return v;
   endfunction

   // Legality from numeric ranges of each immediate format.
   function automatic logic ref_legal(input vec_t v);
      int s;
      s = int'(v.imm);
      case (v.cls)
         4'd0: return 1'b1;
         4'd1: begin
            if (v.f3 == 3'd1 || v.f3 == 3'd5) return v.imm < 32'd32;
            return s >= -2048 && s <= 2047;
         end
         4'd2, 4'd3, 4'd6, 4'd9: return s >= -2048 && s <= 2047;
         4'd4: return s >= -4096 && s <= 4094 && (s % 2) == 0;
         4'd5: return s >= -1048576 && s <= 1048574 && (s % 2) == 0;
         4'd7, 4'd8: return (v.imm % 32'd4096) == 32'd0;
         default: return 1'b0;
      endcase
   endfunction

   // Word built with shifts and masks of the field positions.
   function automatic logic [31:0] ref_word(input vec_t v);
      logic [31:0] op, rd, rs1, rs2, f3, f7, i;
      rd = 32'(v.rd); rs1 = 32'(v.rs1); rs2 = 32'(v.rs2);
      f3 = 32'(v.f3); f7 = 32'(v.f7); i = v.imm;
      case (v.cls)
         4'd0: op = 32'h33; 4'd1: op = 32'h13; 4'd2: op = 32'h03; 4'd3: op = 32'h23;
         4'd4: op = 32'h63; 4'd5: op = 32'h6F; 4'd6: op = 32'h67; 4'd7: op = 32'h37;
         4'd8: op = 32'h17; default: op = 32'h73;
      endcase
      case (v.cls)
         4'd0: return op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
         4'd1, 4'd2, 4'd6, 4'd9: begin
            if (v.cls == 4'd1 && (v.f3 == 3'd1 || v.f3 == 3'd5))
               return op | rd << 7 | f3 << 12 | rs1 << 15 | (i & 32'h1F) << 20 | f7 << 25;
            return op | rd << 7 | f3 << 12 | rs1 << 15 | (i & 32'hFFF) << 20;
         end
         4'd3: return op | (i & 32'h1F) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 |
                      ((i >> 5) & 32'h7F) << 25;
         4'd4: return op | ((i >> 11) & 32'h1) << 7 | ((i >> 1) & 32'hF) << 8 | f3 << 12 |
                      rs1 << 15 | rs2 << 20 | ((i >> 5) & 32'h3F) << 25 |
                      ((i >> 12) & 32'h1) << 31;
         4'd5: return op | rd << 7 | ((i >> 12) & 32'hFF) << 12 | ((i >> 11) & 32'h1) << 20 |
                      ((i >> 1) & 32'h3FF) << 21 | ((i >> 20) & 32'h1) << 31;
         default: return op | rd << 7 | (i & 32'hFFFFF000);
      endcase
   endfunction

   function automatic logic [31:0] rand_imm();
      int r;
      case ($urandom % 6)
         0: r = int'($urandom);
         1: r = int'($urandom_range(0, 4200)) - 2100;
         2: r = int'($urandom_range(0, 8400)) - 4200;
         3: r = int'($urandom_range(0, 2200000)) - 1100000;
         4: r = int'($urandom & 32'hFFFFF000);
         default: r = int'($urandom_range(0, 40));
      endcase
      return 32'(r);
   endfunction

   vec_t        vecs[NV];
   vec_t        v;
   logic [31:0] exp_addr;
   int          exp_cnt;
   logic [31:0] held_word, held_addr;
   // Reference model state for the randomized run.
   logic        m_valid, m_err, m_rdy, m_acc, m_leg;
   logic [31:0] m_word, m_addr, m_next;
   int          m_cnt;

   initial begin
      tests = 0;
      fails = 0;
      vecs[0]  = mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      vecs[0].legal = 1; vecs[0].word = 32'h00500093;
      vecs[1]  = mk(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      vecs[1].legal = 1; vecs[1].word = 32'h002081B3;
      vecs[2]  = mk(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
      vecs[2].legal = 1; vecs[2].word = 32'h0020A423;
      vecs[3]  = mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
      vecs[3].legal = 1; vecs[3].word = 32'hFFDFF0EF;
      vecs[4]  = mk(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      vecs[4].legal = 1; vecs[4].word = 32'h123452B7;
      vecs[5]  = mk(4'd8, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000);
      vecs[5].legal = 1; vecs[5].word = 32'hFFFFF017;
      vecs[6]  = mk(4'd2, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFF);
      vecs[6].legal = 1; vecs[6].word = 32'hFFF1A103;
      vecs[7]  = mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
      vecs[7].legal = 1; vecs[7].word = 32'h00208463;
      vecs[8]  = mk(4'd1, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3);
      vecs[8].legal = 1; vecs[8].word = 32'h4030D093;
      vecs[9]  = mk(4'd6, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0);
      vecs[9].legal = 1; vecs[9].word = 32'h00008067;
      vecs[10] = mk(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      vecs[10].legal = 1; vecs[10].word = 32'h00000073;
      vecs[11] = mk(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000);
      vecs[11].legal = 1; vecs[11].word = 32'h80000063;
      vecs[12] = mk(4'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
      vecs[12].legal = 1; vecs[12].word = 32'h7FF00013;
      vecs[13] = mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
      vecs[14] = mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
      vecs[15] = mk(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      vecs[16] = mk(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001);
      vecs[17] = mk(4'd1, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32);
      vecs[18] = mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000);
      vecs[19] = mk(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF7FF);

      rst = 1'b1;
      bus.clr_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
      drive(vecs[0]);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst out_valid", 32'(bus.out_valid_o), 32'd0);
      check("rst word", bus.word_o, 32'd0);
      check("rst addr", bus.addr_o, BASE);
      check("rst err", 32'(bus.err_o), 32'd0);
      check("rst err_cnt", 32'(bus.err_cnt_o), 32'd0);
      check("rst in_ready", 32'(bus.in_ready_o), 32'd1);

      // Fixed vectors, one descriptor per cycle.
      exp_addr = BASE;
      exp_cnt  = 0;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         bus.in_valid_i = 1'b1;
         tick();
         bus.in_valid_i = 1'b0;
         check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid_o), 32'(vecs[i].legal));
         check($sformatf("vec%0d err", i), 32'(bus.err_o), 32'(!vecs[i].legal));
         if (vecs[i].legal) begin
            check($sformatf("vec%0d word", i), bus.word_o, vecs[i].word);
            check($sformatf("vec%0d addr", i), bus.addr_o, exp_addr);
            exp_addr = exp_addr + 32'd4;
         end else begin
            exp_cnt++;
         end
         check($sformatf("vec%0d err_cnt", i), 32'(bus.err_cnt_o), 32'(exp_cnt));
      end
      tick();
      check("idle err clears", 32'(bus.err_o), 32'd0);
      check("idle drains", 32'(bus.out_valid_o), 32'd0);

      // Back-to-back arr then st with in_ready held high.
      drive(vecs[1]); bus.in_valid_i = 1'b1; #1;
      check("b2b ready0", 32'(bus.in_ready_o), 32'd1);
      tick();
      check("b2b word0", bus.word_o, 32'h002081B3);
      check("b2b addr0", bus.addr_o, exp_addr);
      drive(vecs[2]); #1;
      check("b2b ready1", 32'(bus.in_ready_o), 32'd1);
      tick();
      bus.in_valid_i = 1'b0;
      check("b2b word1", bus.word_o, 32'h0020A423);
      check("b2b addr1", bus.addr_o, exp_addr + 32'd4);
      exp_addr = exp_addr + 32'd8;
      tick();

      // Three consecutive rejects: pulses each cycle, count +3, no word, no address step.
      bus.in_valid_i = 1'b1;
      for (int i = 13; i <= 15; i++) begin
         drive(vecs[i]);
         tick();
         check($sformatf("rej%0d err", i), 32'(bus.err_o), 32'd1);
         check($sformatf("rej%0d out_valid", i), 32'(bus.out_valid_o), 32'd0);
      end
      exp_cnt += 3;
      drive(vecs[0]);
      tick();
      bus.in_valid_i = 1'b0;
      check("rej cnt", 32'(bus.err_cnt_o), 32'(exp_cnt));
      check("rej addr kept", bus.addr_o, exp_addr);
      check("rej err drop", 32'(bus.err_o), 32'd0);
      exp_addr = exp_addr + 32'd4;
      tick();

      // Backpressure: word held for 5 cycles, next word follows on release.
      bus.out_ready_i = 1'b0;
      drive(vecs[7]); bus.in_valid_i = 1'b1;
      tick();
      held_word = bus.word_o;
      held_addr = bus.addr_o;
      check("stall first word", held_word, 32'h00208463);
      check("stall first addr", held_addr, exp_addr);
      drive(vecs[4]);
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("stall%0d in_ready", i), 32'(bus.in_ready_o), 32'd0);
         check($sformatf("stall%0d word", i), bus.word_o, held_word);
         check($sformatf("stall%0d addr", i), bus.addr_o, held_addr);
         tick();
      end
      bus.out_ready_i = 1'b1; #1;
      check("release in_ready", 32'(bus.in_ready_o), 32'd1);
      tick();
      bus.in_valid_i = 1'b0;
      check("release word", bus.word_o, 32'h123452B7);
      check("release addr", bus.addr_o, exp_addr + 32'd4);
      tick();

      // Clear beats a coincident legal accept.
      drive(vecs[0]); bus.in_valid_i = 1'b1; bus.clr_i = 1'b1;
      tick();
      bus.clr_i = 1'b0;
      check("clr out_valid", 32'(bus.out_valid_o), 32'd0);
      check("clr err", 32'(bus.err_o), 32'd0);
      check("clr err_cnt kept", 32'(bus.err_cnt_o), 32'(exp_cnt));
      tick();
      bus.in_valid_i = 1'b0;
      check("post-clr word", bus.word_o, 32'h00500093);
      check("post-clr addr", bus.addr_o, BASE);

      // Asynchronous reset while a word is held.
      bus.out_ready_i = 1'b0;
      drive(vecs[3]); bus.in_valid_i = 1'b1;
      tick();
      bus.in_valid_i = 1'b0;
      check("pre-rst held", 32'(bus.out_valid_o), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst out_valid", 32'(bus.out_valid_o), 32'd0);
      check("midrst word", bus.word_o, 32'd0);
      check("midrst addr", bus.addr_o, BASE);
      check("midrst err_cnt", 32'(bus.err_cnt_o), 32'd0);
      rst = 1'b0;

      // Randomized run against the reference model, starting from reset state.
      m_valid = 1'b0; m_err = 1'b0; m_word = '0; m_addr = BASE; m_next = BASE; m_cnt = 0;
      for (int c = 0; c < 2000; c++) begin
         v = mk(($urandom % 8 == 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 10),
                5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                ($urandom % 2 == 0) ? 7'h20 : 7'($urandom), rand_imm());
         drive(v);
         bus.in_valid_i  = ($urandom % 4) != 0;
         bus.out_ready_i = ($urandom % 3) != 0;
         bus.clr_i       = ($urandom % 40) == 0;
         #1;
         m_rdy = !m_valid || bus.out_ready_i;
         check($sformatf("rnd%0d in_ready", c), 32'(bus.in_ready_o), 32'(m_rdy));
         m_acc = bus.in_valid_i && m_rdy;
         m_leg = ref_legal(v);
         m_err = 1'b0;
         if (bus.clr_i) begin
            m_valid = 1'b0;
            m_next  = BASE;
         end else if (m_acc && m_leg) begin
            m_valid = 1'b1;
            m_word  = ref_word(v);
            m_addr  = m_next;
            m_next  = m_next + 32'd4;
         end else begin
            if (m_acc) begin
               m_err = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
            if (bus.out_ready_i) m_valid = 1'b0;
         end
         tick();
         check($sformatf("rnd%0d out_valid", c), 32'(bus.out_valid_o), 32'(m_valid));
         if (m_valid) begin
            check($sformatf("rnd%0d word", c), bus.word_o, m_word);
            check($sformatf("rnd%0d addr", c), bus.addr_o, m_addr);
         end
         check($sformatf("rnd%0d err", c), 32'(bus.err_o), 32'(m_err));
         check($sformatf("rnd%0d err_cnt", c), 32'(bus.err_cnt_o), 32'(m_cnt));
      end
      bus.clr_i = 1'b0;
      bus.in_valid_i = 1'b0;

      // Counter saturation after 300 rejects from a fresh reset.
      rst = 1'b1; #1 rst = 1'b0;
      bus.out_ready_i = 1'b1;
      drive(mk(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
      bus.in_valid_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 254) check("sat reach 255", 32'(bus.err_cnt_o), 32'd255);
      end
      bus.in_valid_i = 1'b0;
      check("sat err_cnt", 32'(bus.err_cnt_o), 32'd255);
      check("sat err", 32'(bus.err_o), 32'd1);
      check("sat out_valid", 32'(bus.out_valid_o), 32'd0);
      tick();
      check("sat err drop", 32'(bus.err_o), 32'd0);
      check("sat hold", 32'(bus.err_cnt_o), 32'd255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
